// File: rtl/switch_select_encoder.sv
// Debounced four-switch selector: the latest pressed switch is encoded onto o_Select_1/o_Select_0.
// Define SELECT_RELEASE_CLEAR_EN to clear the selection when the selected switch is released.
module switch_select_encoder #(
    parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    input  logic i_Switch_3,
    input  logic i_Switch_4,
    output logic o_Select_0,
    output logic o_Select_1,
    output logic o_Valid,
    output logic o_Change
);

    // Counter only needs to reach DEBOUNCE_LIMIT-1 before the state flips.
    localparam int unsigned CNT_W = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    typedef enum logic {
        SEL_NONE,
        SEL_HELD
    } sel_state_t;

    logic [3:0]       raw;
    logic [3:0]       sync_a;
    logic [3:0]       sync_b;
    logic [3:0]       deb;
    logic [3:0]       deb_q;
    logic [CNT_W-1:0] cnt [4];

    logic [3:0]       press;
    logic [3:0]       release_evt;
    logic             press_any;
    logic [1:0]       press_idx;

    sel_state_t       state;
    logic [1:0]       sel;
    logic             valid_r;
    logic             change_r;

    assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync_a <= '0;
            sync_b <= '0;
            deb    <= '0;
            deb_q  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            deb_q  <= deb;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync_b[i] != deb[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        deb[i] <= sync_b[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign press       = deb & ~deb_q;
    assign release_evt = ~deb & deb_q;

    // Lowest-numbered switch wins when several presses land together.
    always_comb begin
        press_any = 1'b0;
        press_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (press[i] && !press_any) begin
                press_any = 1'b1;
                press_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state    <= SEL_NONE;
            sel      <= '0;
            valid_r  <= 1'b0;
            change_r <= 1'b0;
        end else begin
            change_r <= 1'b0;
            case (state)
                SEL_NONE: begin
                    if (press_any) begin
                        state    <= SEL_HELD;
                        sel      <= press_idx;
                        valid_r  <= 1'b1;
                        change_r <= 1'b1;
                    end
                end
                SEL_HELD: begin
                    if (press_any && (press_idx != sel)) begin
                        sel      <= press_idx;
                        change_r <= 1'b1;
`ifdef SELECT_RELEASE_CLEAR_EN
                    end else if (!press_any && release_evt[sel]) begin
                        state    <= SEL_NONE;
                        sel      <= '0;
                        valid_r  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= SEL_NONE;
                end
            endcase
        end
    end

`ifndef SELECT_RELEASE_CLEAR_EN
    // Releases do not affect a sticky selection.
    logic unused_release;
    assign unused_release = ^release_evt;
`endif

    assign o_Select_0 = sel[0];
    assign o_Select_1 = sel[1];
    assign o_Valid    = valid_r;
    assign o_Change   = change_r;

endmodule
